updown_counter_n: RTL and testbench
===================================

Name: updown_counter_n

Overview:
Parametrised synchronous modulo-N up/down counter with enable, parallel load, a terminal-count output for cascading, and a built-in hex 7-segment decode of the count's low nibble. It is the general-purpose successor to the fixed 3-bit ripple-style JK counter. It feeds board-level seven-segment displays and chains into multi-digit counters: oTC of one stage drives iEn of the next.

Parameters:
WIDTH, 4, count register width in bits; legal range 1..16.
MODULUS, 10, count sequence length; the counter runs 0..MODULUS-1; legal range 2..2^WIDTH.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  synchronous active-low reset; sampled on the CLK rising edge.
iEn  input  1  count enable; one step per cycle while high.
iUp  input  1  direction: 1 = increment, 0 = decrement.
iLoad  input  1  parallel load strobe.
iLoadVal  input  WIDTH  value to load.
oQ  output  WIDTH  current count, registered.
oTC  output  1  terminal count; combinational.
oDisplay  output  7  segment drive {g,f,e,d,c,b,a}, active-high; combinational from oQ.

Behaviour:
- Reset: rst_n low at a CLK edge sets oQ = 0. Reset has priority over load and count. While rst_n is low, oTC = 0 and oDisplay = 7'h3F ("0").
- Priority at each CLK edge with rst_n high: iLoad, then iEn, then hold.
- Load: oQ <= iLoadVal if iLoadVal < MODULUS, otherwise oQ <= MODULUS-1 (clipped). iEn and iUp are ignored in a load cycle.
- Count up (iEn=1, iUp=1): oQ <= oQ+1. If oQ == MODULUS-1, oQ <= 0 (wrap).
- Count down (iEn=1, iUp=0): oQ <= oQ-1. If oQ == 0, oQ <= MODULUS-1 (wrap).
- Hold: when iEn=0 and iLoad=0, oQ is unchanged.
- oTC = rst_n & iEn & ~iLoad & ((iUp & oQ==MODULUS-1) | (~iUp & oQ==0)).
  - Asserted in the same cycle as the wrapping edge, so a downstream stage clocked by the same CLK steps on that same edge.
- Direction may change on any cycle. The new direction takes effect on the next edge, with no dead cycle.
- Arithmetic is performed in WIDTH+1 bits internally. No intermediate overflow when MODULUS = 2^WIDTH. oQ never holds a value >= MODULUS.
- oDisplay decodes oQ[3:0]. When WIDTH < 4, oQ is zero-extended to 4 bits first.
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset mid-operation: all state is discarded and no partial step completes. The first count after rst_n rises starts from 0.
- No latches. Every output is fully defined for all input combinations, including X-free values immediately after the reset edge.

Optional Feature:
Macro: UPDOWN_COUNTER_N_SAT_EN.
- Defined: saturating mode.
  - Counting up at MODULUS-1 holds MODULUS-1.
  - Counting down at 0 holds 0.
  - oTC is still asserted under the same condition, marking an attempted overflow or underflow.
  - Load and reset behaviour are unchanged.
- Not defined: wrap-around behaviour as specified above.
- The oTC equation and port list are identical in both builds.

Test Plan:
1. Reset hold (defaults WIDTH=4, MODULUS=10): rst_n=0 for 3 cycles with iEn=1 -> oQ=0, oTC=0, oDisplay=7'h3F. Release rst_n with iEn=1, iUp=1 -> oQ=1 after the first edge, oDisplay=7'h06.
2. Up wrap: iEn=1, iUp=1 from 0 for 10 edges -> oQ steps 1..9 then 0. oTC=1 only in the cycle where oQ=9. oDisplay=7'h6F at 9. In SAT_EN build, oQ stays 9 and oTC stays 1.
3. Down wrap: load 0, then iEn=1, iUp=0 -> next edge oQ=9 with oTC=1 in the preceding cycle. Next edges give 8, 7. In SAT_EN build, oQ stays 0.
4. Load priority and clip: oQ=4, iEn=1, iLoad=1, iLoadVal=7 -> oQ=7 and oTC=0 that cycle. Then iLoadVal=12 -> oQ=9.
5. Enable/direction: iEn=0 for 5 cycles at oQ=6 -> oQ stays 6. Toggle iUp each cycle with iEn=1 -> 7, 6, 7, 6.
6. Cascade and reset mid-count: two instances, the second's iEn driven by the first's oTC, counted up from 00 -> tens digit increments exactly when units wrap 9->0 (09->10, 99->00). Assert rst_n=0 at 57 -> both read 0 on the next edge.
   - Also run WIDTH=3, MODULUS=8 -> sequence 0..7 wraps, oDisplay shows 0..7.

Source files
------------

// File: rtl/updown_counter_n.sv
// Modulo-MODULUS up/down counter with parallel load, cascade terminal count and hex 7-segment decode.
// Define UPDOWN_COUNTER_N_SAT_EN to saturate at 0 / MODULUS-1 instead of wrapping.
module updown_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic [6:0]       oDisplay
);

  localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] LP_ONE = (WIDTH+1)'(1);

  function automatic logic [6:0] f_seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    f_seg7 = 7'h3F;
      4'h1:    f_seg7 = 7'h06;
      4'h2:    f_seg7 = 7'h5B;
      4'h3:    f_seg7 = 7'h4F;
      4'h4:    f_seg7 = 7'h66;
      4'h5:    f_seg7 = 7'h6D;
      4'h6:    f_seg7 = 7'h7D;
      4'h7:    f_seg7 = 7'h07;
      4'h8:    f_seg7 = 7'h7F;
      4'h9:    f_seg7 = 7'h6F;
      4'hA:    f_seg7 = 7'h77;
      4'hB:    f_seg7 = 7'h7C;
      4'hC:    f_seg7 = 7'h39;
      4'hD:    f_seg7 = 7'h5E;
      4'hE:    f_seg7 = 7'h79;
      default: f_seg7 = 7'h71;
    endcase
  endfunction

  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic [3:0]       w_nib_raw;
  logic [3:0]       w_nib;

  // One spare bit keeps q+1 exact even when MODULUS == 2^WIDTH.
  assign w_q_ext   = {1'b0, r_q};
  assign w_at_max  = (w_q_ext == LP_MAX);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_next = w_q_ext;
    if (iLoad) begin
      w_next = {1'b0, iLoadVal};
    end else if (iEn) begin
      if (iUp) begin
        if (w_at_max) begin
`ifdef UPDOWN_COUNTER_N_SAT_EN
          w_next = LP_MAX;
`else
          w_next = '0;
`endif
        end else begin
          w_next = w_q_ext + LP_ONE;
        end
      end else begin
        if (w_at_zero) begin
`ifdef UPDOWN_COUNTER_N_SAT_EN
          w_next = '0;
`else
          w_next = LP_MAX;
`endif
        end else begin
          w_next = w_q_ext - LP_ONE;
        end
      end
    end
  end

  // The final clamp clips out-of-range loads and keeps oQ below MODULUS.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (w_next > LP_MAX) begin
      r_q <= LP_MAX[WIDTH-1:0];
    end else begin
      r_q <= w_next[WIDTH-1:0];
    end
  end

  generate
    if (WIDTH >= 4) begin : g_nib_wide
      assign w_nib_raw = r_q[3:0];
    end else begin : g_nib_narrow
      assign w_nib_raw = {{(4-WIDTH){1'b0}}, r_q};
    end
  endgenerate

  // Display reads "0" throughout reset, even before the first reset edge.
  assign w_nib    = rst_n ? w_nib_raw : 4'h0;
  assign oDisplay = f_seg7(w_nib);
  assign oQ       = r_q;
  assign oTC      = rst_n & iEn & ~iLoad & ((iUp & w_at_max) | (~iUp & w_at_zero));

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench: units/tens cascade of 10-state counters plus a standalone 3-bit modulo-8 counter.
module tb_updown_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en_a = 1'b0, up_a = 1'b1, ld_a = 1'b0;
  logic [3:0] lv_a = 4'd0;
  logic       en_c = 1'b0, up_c = 1'b1, ld_c = 1'b0;
  logic [2:0] lv_c = 3'd0;
  logic [3:0] q_a, q_b;
  logic [2:0] q_c;
  logic       tc_a, tc_b, tc_c;
  logic [6:0] d_a, d_b, d_c;

  updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_units (
    .CLK(clk), .rst_n(rst_n), .iEn(en_a), .iUp(up_a), .iLoad(ld_a), .iLoadVal(lv_a),
    .oQ(q_a), .oTC(tc_a), .oDisplay(d_a));

  updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_tens (
    .CLK(clk), .rst_n(rst_n), .iEn(tc_a), .iUp(up_a), .iLoad(1'b0), .iLoadVal(4'd0),
    .oQ(q_b), .oTC(tc_b), .oDisplay(d_b));

  updown_counter_n #(.WIDTH(3), .MODULUS(8)) u_oct (
    .CLK(clk), .rst_n(rst_n), .iEn(en_c), .iUp(up_c), .iLoad(ld_c), .iLoadVal(lv_c),
    .oQ(q_c), .oTC(tc_c), .oDisplay(d_c));

  typedef struct {
    int qa, qb, qc;
    int tca, tcb, tcc;
    int da, db, dc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state; -1 means "not yet defined" (before the first reset edge).
  int mqa = -1, mqb = -1, mqc = -1;
  int c_en = 1, c_up = 1, c_ld = 0, c_lv = 0;

  int seg_tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  function automatic int m_next(int q, int m, int r, int ld, int lv, int en, int up);
    if (r == 0) return 0;
    if (ld != 0) return (lv < m) ? lv : m - 1;
    if (en == 0) return q;
`ifdef UPDOWN_COUNTER_N_SAT_EN
    if (up != 0) return (q == m - 1) ? q : q + 1;
    return (q == 0) ? 0 : q - 1;
`else
    if (up != 0) return (q + 1) % m;
    return (q + m - 1) % m;
`endif
  endfunction

  function automatic int m_tc(int q, int m, int r, int ld, int en, int up);
    if (r == 0 || en == 0 || ld != 0) return 0;
    if (up != 0) return (q == m - 1) ? 1 : 0;
    return (q == 0) ? 1 : 0;
  endfunction

  function automatic int m_disp(int q, int r);
    if (r == 0) return 'h3F;
    return seg_tbl[q % 16];
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int r, input int ea, input int ua, input int la, input int lva);
    exp_t e;
    @(negedge clk);
    rst_n = 1'(r);
    en_a  = 1'(ea);
    up_a  = 1'(ua);
    ld_a  = 1'(la);
    lv_a  = 4'(lva);
    en_c  = 1'(c_en);
    up_c  = 1'(c_up);
    ld_c  = 1'(c_ld);
    lv_c  = 3'(c_lv);
    e.qa  = mqa;
    e.tca = m_tc(mqa, 10, r, la, ea, ua);
    e.da  = m_disp(mqa, r);
    e.qb  = mqb;
    e.tcb = m_tc(mqb, 10, r, 0, e.tca, ua);
    e.db  = m_disp(mqb, r);
    e.qc  = mqc;
    e.tcc = m_tc(mqc, 8, r, c_ld, c_en, c_up);
    e.dc  = m_disp(mqc, r);
    sb.push_back(e);
    mqb = m_next(mqb, 10, r, 0, 0, e.tca, ua);
    mqa = m_next(mqa, 10, r, la, lva, ea, ua);
    mqc = m_next(mqc, 8, r, c_ld, c_lv, c_en, c_up);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.qa >= 0) chk("units_q", int'(q_a), e.qa);
        if (e.qb >= 0) chk("tens_q", int'(q_b), e.qb);
        if (e.qc >= 0) chk("oct_q", int'(q_c), e.qc);
        chk("units_tc", int'(tc_a), e.tca);
        chk("tens_tc", int'(tc_b), e.tcb);
        chk("oct_tc", int'(tc_c), e.tcc);
        chk("units_disp", int'(d_a), e.da);
        chk("tens_disp", int'(d_b), e.db);
        chk("oct_disp", int'(d_c), e.dc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Reset held with enable high, then release and count.
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (2) step(1, 1, 1, 0, 0);
    // Up wrap through 9 -> 0.
    step(1, 0, 1, 1, 0);
    repeat (11) step(1, 1, 1, 0, 0);
    // Down wrap from 0.
    step(1, 0, 1, 1, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    // Load priority over count, then clipped load.
    step(1, 0, 1, 1, 4);
    step(1, 1, 1, 1, 7);
    step(1, 1, 0, 1, 12);
    step(1, 0, 1, 0, 15);
    // Hold, then direction toggling every cycle.
    step(1, 0, 1, 1, 6);
    repeat (5) step(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, (i % 2 == 0) ? 1 : 0, 0, 0);
    // Cascade: 00 -> 99 -> 00, then count to 57 and reset mid-count.
    step(0, 1, 1, 0, 0);
    repeat (100) step(1, 1, 1, 0, 0);
    repeat (57) step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0);
    // Randomised traffic on all three counters.
    for (int i = 0; i < 400; i++) begin
      c_en = ($urandom % 4 != 0) ? 1 : 0;
      c_up = int'($urandom % 2);
      c_ld = ($urandom % 8 == 0) ? 1 : 0;
      c_lv = int'($urandom % 8);
      step(($urandom % 40 != 0) ? 1 : 0, ($urandom % 4 != 0) ? 1 : 0,
           int'($urandom % 2), ($urandom % 8 == 0) ? 1 : 0, int'($urandom % 16));
    end
    repeat (2) @(negedge clk);
    #4;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
